// File: rtl/udp_feed_pkg.sv
// Shared definitions for the UDP payload feeder: FSM encoding and sizing helpers.
package udp_feed_pkg;

  // Largest UDP payload that fits a standard 1500-byte Ethernet MTU.
  localparam int unsigned MAX_UDP_PAYLOAD = 1472;

  // Feeder FSM encoding.
  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StStart    = 2'd1;
  localparam logic [1:0] StSend     = 2'd2;
  localparam logic [1:0] StWaitDone = 2'd3;

  // Number of 32-bit words needed to carry n bytes.
  function automatic int unsigned ceil_div4(input int unsigned n);
    return (n + 3) / 4;
  endfunction

endpackage

// File: rtl/payload_snapshot_fifo.sv
// Register-based FIFO holding complete payload snapshots. The head entry is
// read straight from the storage flops so a pop can capture it in the same cycle.
module payload_snapshot_fifo #(
  parameter int unsigned WIDTH = 88,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW:0]     level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Snapshot storage; at full, push and pop share a slot and the pop sees the old entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == (PtrW + 1)'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/udp_payload_feeder.sv
// Payload source for the UDP transmit path: queues payload snapshots on trigger,
// then feeds each one to the udp block as 32-bit words over tx_req/tx_data.
module udp_payload_feeder
  import udp_feed_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 11,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TIMEOUT       = 65535,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8*PAYLOAD_BYTES-1:0] i_payload,
  input  logic                       trigger_valid,
  output logic                       tx_start_en,
  output logic [15:0]                tx_byte_num,
  input  logic                       tx_req,
  output logic [31:0]                tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           timeout_cnt
);

  localparam int unsigned Words = ceil_div4(PAYLOAD_BYTES);
  localparam int unsigned PayW  = 8 * PAYLOAD_BYTES;
  localparam int unsigned PadW  = 32 * Words;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned TmrW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > MAX_UDP_PAYLOAD) begin : g_bad_len
    $error("PAYLOAD_BYTES must be in 1..MAX_UDP_PAYLOAD");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end

  logic [1:0]      state_q;
  logic [PayW-1:0] pkt_q;
  logic [IdxW-1:0] word_idx_q;
  logic [TmrW-1:0] timer_q;
  logic [31:0]     tx_data_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] timeout_cnt_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic [PayW-1:0] fifo_head;
  logic            pop;
  logic            push;
  logic            drop;
  logic            timeout_hit;
  logic [PadW-1:0] pkt_pad;
  logic [31:0]     word_sel;

  assign pop         = (state_q == StIdle) && !fifo_empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push        = trigger_valid && (!fifo_full || pop);
  assign drop        = trigger_valid && !push;
  assign timeout_hit = (state_q == StWaitDone) && !tx_done && (timer_q == TmrW'(TIMEOUT - 1));

  payload_snapshot_fifo #(
    .WIDTH (PayW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (i_payload),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Left-align the packet in a word-multiple vector; trailing pad bytes read as zero.
  always_comb begin
    pkt_pad = '0;
    pkt_pad[PadW-1 -: PayW] = pkt_q;
  end

  assign word_sel = 32'(pkt_pad >> (32 * (Words - 1 - 32'(word_idx_q))));

  // Packet sequencing: pop into the packet register, start pulse, word delivery, done wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pkt_q      <= '0;
      word_idx_q <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            pkt_q      <= fifo_head;
            word_idx_q <= '0;
            state_q    <= StStart;
          end
        end
        StStart: state_q <= StSend;
        StSend: begin
          if (tx_req) begin
            tx_data_q  <= word_sel;
            word_idx_q <= word_idx_q + IdxW'(1);
            if (word_idx_q == IdxW'(Words - 1)) begin
              timer_q <= '0;
              state_q <= StWaitDone;
            end
          end
        end
        StWaitDone: begin
          // Extra requests past the last word get zero filler.
          if (tx_req) tx_data_q <= '0;
          if (tx_done || timeout_hit) state_q <= StIdle;
          else                        timer_q <= timer_q + TmrW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating drop and timeout counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      if (drop && (drop_cnt_q != '1))           drop_cnt_q    <= drop_cnt_q + CNT_W'(1);
      if (timeout_hit && (timeout_cnt_q != '1)) timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
    end
  end

  assign tx_start_en = (state_q == StStart);
  assign busy        = (state_q != StIdle);
  assign tx_data     = tx_data_q;
  assign tx_byte_num = 16'(PAYLOAD_BYTES);
  assign drop_cnt    = drop_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_udp_payload_feeder.sv
// Self-checking bench for udp_payload_feeder: directed scenarios plus random
// traffic, all checked against a packet-level reference model.
module tb_udp_payload_feeder;

  localparam int unsigned PB      = 11;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned WORDS   = (PB + 3) / 4;
  localparam int PH_IDLE = 0, PH_START = 1, PH_SEND = 2, PH_WAIT = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*PB-1:0] i_payload = '0;
  logic            trigger_valid = 1'b0;
  logic            tx_req = 1'b0;
  logic            tx_done = 1'b0;
  logic            tx_start_en;
  logic [15:0]     tx_byte_num;
  logic [31:0]     tx_data;
  logic            busy;
  logic [2:0]      fifo_level;
  logic [15:0]     drop_cnt;
  logic [15:0]     timeout_cnt;

  // Second instance for the 4-byte payload case.
  logic [31:0] pay4 = '0;
  logic        trig4 = 1'b0, req4 = 1'b0, done4 = 1'b0;
  logic        start4, busy4;
  logic [15:0] bn4, drop4, tmo4;
  logic [31:0] data4;
  logic [1:0]  lvl4;

  always #5 clk = ~clk;

  udp_payload_feeder #(
    .PAYLOAD_BYTES (PB),
    .DEPTH         (DEPTH),
    .TIMEOUT       (TIMEOUT),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_payload     (i_payload),
    .trigger_valid (trigger_valid),
    .tx_start_en   (tx_start_en),
    .tx_byte_num   (tx_byte_num),
    .tx_req        (tx_req),
    .tx_data       (tx_data),
    .tx_done       (tx_done),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .drop_cnt      (drop_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  udp_payload_feeder #(
    .PAYLOAD_BYTES (4),
    .DEPTH         (2),
    .TIMEOUT       (16),
    .CNT_W         (16)
  ) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_payload     (pay4),
    .trigger_valid (trig4),
    .tx_start_en   (start4),
    .tx_byte_num   (bn4),
    .tx_req        (req4),
    .tx_data       (data4),
    .tx_done       (done4),
    .busy          (busy4),
    .fifo_level    (lvl4),
    .drop_cnt      (drop4),
    .timeout_cnt   (tmo4)
  );

  // Reference model: queue of snapshots plus the in-flight packet's progress.
  logic [8*PB-1:0] m_q[$];
  logic [8*PB-1:0] m_pkt;
  int              m_phase = PH_IDLE;
  int              m_sent, m_wait, m_drop, m_tmo;
  logic [31:0]     m_data;
  bit              m_chk_data, m_loaded;

  int          n_cmp = 0, n_err = 0;
  int          n_start, peak;
  logic [31:0] cap[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Word k of a payload: bytes 4k..4k+3, first byte most significant, zero past the end.
  function automatic logic [31:0] exp_word(input logic [8*PB-1:0] p, input int k);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      int   idx;
      logic [7:0] by;
      idx = 4 * k + b;
      by  = 8'h00;
      if (idx < int'(PB)) by = 8'((p >> (8 * (int'(PB) - 1 - idx))) & 88'hFF);
      w = (w << 8) | 32'(by);
    end
    return w;
  endfunction

  function automatic logic [8*PB-1:0] rand_payload();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[8*PB-1:0];
  endfunction

  // Advance the model across one clock edge using the inputs presented this cycle.
  task automatic model_edge();
    bit pop, accept;
    m_chk_data = 0;
    m_loaded   = 0;
    if (!rst_n) begin
      m_q.delete();
      m_phase = PH_IDLE;
      m_drop = 0;
      m_tmo = 0;
      m_data = '0;
      m_chk_data = 1;
    end else begin
      pop    = (m_phase == PH_IDLE) && (m_q.size() > 0);
      accept = trigger_valid && ((m_q.size() < int'(DEPTH)) || pop);
      if (trigger_valid && !accept && m_drop < 65535) m_drop++;
      case (m_phase)
        PH_IDLE: if (pop) begin
          m_pkt = m_q.pop_front();
          m_sent = 0;
          m_phase = PH_START;
        end
        PH_START: m_phase = PH_SEND;
        PH_SEND: if (tx_req) begin
          m_data = exp_word(m_pkt, m_sent);
          m_chk_data = 1;
          m_loaded = 1;
          m_sent++;
          if (m_sent == int'(WORDS)) begin
            m_phase = PH_WAIT;
            m_wait = 0;
          end
        end
        PH_WAIT: begin
          if (tx_req) begin
            m_data = '0;
            m_chk_data = 1;
          end
          if (tx_done) m_phase = PH_IDLE;
          else if (m_wait == int'(TIMEOUT) - 1) begin
            m_phase = PH_IDLE;
            if (m_tmo < 65535) m_tmo++;
          end else m_wait++;
        end
        default: ;
      endcase
      if (accept) m_q.push_back(i_payload);
    end
  endtask

  task automatic compare();
    chk("tx_start_en", 32'(tx_start_en), 32'(m_phase == PH_START));
    chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tmo));
    if (m_chk_data) chk("tx_data", tx_data, m_data);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
    if (m_loaded) cap.push_back(tx_data);
    if (tx_start_en === 1'b1) n_start++;
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trigger_valid = 1'b0;
    tx_req = 1'b0;
    tx_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Act as the udp block: request words continuously, finish each frame at once.
  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    tx_req = 1'b1;
    while (!(m_phase == PH_IDLE && m_q.size() == 0) && n < max_cycles) begin
      tx_done = (m_phase == PH_WAIT);
      tick();
      n++;
    end
    tx_done = 1'b0;
    tx_req = 1'b0;
    chk("drain_bound", 32'(n < max_cycles), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;
    logic [31:0] want1 [3];
    want1[0] = 32'h00112233;
    want1[1] = 32'h44556677;
    want1[2] = 32'h8899AA00;

    // Single 11-byte packet with fixed contents.
    do_reset();
    cap.delete();
    i_payload = 88'h00112233445566778899AA;
    trigger_valid = 1'b1;
    tx_req = 1'b1;
    tick();
    trigger_valid = 1'b0;
    lat = -1;
    // Tick count from the trigger cycle: trigger, pop, start.
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (tx_start_en === 1'b1 && lat < 0) lat = c;
    end
    chk("t1_start_latency", 32'(lat), 32'd2);
    chk("t1_word_count", 32'(cap.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("t1_word", (k < cap.size()) ? cap[k] : 32'hxxxxxxxx, want1[k]);
    chk("t1_busy_wait", 32'(busy), 32'd1);
    tx_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t1_busy_after_done", 32'(busy), 32'd0);
    chk("t1_byte_num", 32'(tx_byte_num), 32'd11);

    // Six back-to-back triggers with the first packet stalled: one in flight, four queued.
    do_reset();
    peak = 0;
    n_start = 0;
    for (int i = 0; i < 6; i++) begin
      i_payload = rand_payload() ^ 88'(i);
      trigger_valid = 1'b1;
      tick();
    end
    trigger_valid = 1'b0;
    chk("t2_peak_level", 32'(peak), 32'd4);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    drain(300);
    chk("t2_packets", 32'(n_start), 32'd5);

    // Trigger lands on the IDLE pop cycle while the FIFO is full.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_payload = rand_payload();
      trigger_valid = 1'b1;
      tick();
    end
    trigger_valid = 1'b0;
    tx_req = 1'b1;
    n = 0;
    while (m_phase != PH_WAIT && n < 20) begin
      tick();
      n++;
    end
    tx_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t3_full_before", 32'(fifo_level), 32'd4);
    i_payload = rand_payload();
    trigger_valid = 1'b1;
    tick();
    trigger_valid = 1'b0;
    chk("t3_level_same", 32'(fifo_level), 32'd4);
    chk("t3_no_drop", 32'(drop_cnt), 32'd0);
    drain(300);

    // Timeout with a second packet queued behind.
    do_reset();
    tx_req = 1'b1;
    i_payload = rand_payload();
    trigger_valid = 1'b1;
    tick();
    i_payload = rand_payload();
    tick();
    trigger_valid = 1'b0;
    n = 0;
    while (m_phase != PH_WAIT && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_wait_cycles", 32'(n), 32'(TIMEOUT));
    chk("t4_timeout_cnt", 32'(timeout_cnt), 32'd1);
    drain(300);
    chk("t4_timeout_after", 32'(timeout_cnt), 32'd1);

    // Reset mid-SEND with two entries queued (timeout_cnt is 1 going in).
    tx_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_payload = rand_payload();
      trigger_valid = 1'b1;
      tick();
    end
    trigger_valid = 1'b0;
    chk("t6_level_before", 32'(fifo_level), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_tx_data", tx_data, 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_timeout", 32'(timeout_cnt), 32'd0);
    n_start = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_no_start", 32'(n_start), 32'd0);

    // Random traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      i_payload     = rand_payload();
      trigger_valid = ($urandom_range(0, 99) < 20);
      tx_req        = ($urandom_range(0, 99) < 50);
      tx_done       = ($urandom_range(0, 99) < 12);
      rst_n         = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1;
    trigger_valid = 1'b0;
    tx_req = 1'b0;
    tx_done = 1'b0;
    do_reset();

    // Four-byte payload: one word, then zero filler in WAIT_DONE.
    pay4 = 32'hDEADBEEF;
    trig4 = 1'b1;
    tick();
    trig4 = 1'b0;
    n = 0;
    while (start4 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("t5_start_seen", 32'(start4), 32'd1);
    tick();
    req4 = 1'b1;
    tick();
    chk("t5_word", data4, 32'hDEADBEEF);
    tick();
    chk("t5_pad_word", data4, 32'h0);
    req4 = 1'b0;
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
    chk("t5_busy", 32'(busy4), 32'd0);
    chk("t5_byte_num", 32'(bn4), 32'd4);
    chk("t5_level", 32'(lvl4), 32'd0);
    chk("t5_drop", 32'(drop4), 32'd0);
    chk("t5_timeout", 32'(tmo4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
